alu_top: RTL and testbench
==========================

# alu_top

Board-level ALU wrapper: three capture registers (operand A, operand B, opcode) loaded from a shared switch bank under button control, feeding a combinational 8-operation ALU whose result drives the LEDs. Top of the FPGA ALU design; switches and buttons are external board inputs. Buttons arrive already synchronised and debounced.

## Interface
- SIZEDATA, 8, width of operands, switches and LEDs
- SIZEOP, 6, opcode width (low SIZEOP bits of SWITCHES)
- N_BUTTONS, 3, number of load buttons
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- SWITCHES  input  SIZEDATA  shared data/opcode input bus
- BUTTONS  input  N_BUTTONS  load enables: [0] operand A, [1] operand B, [2] opcode
- LEDS  output  SIZEDATA  ALU result

## Operation
- Registers: reg_a[SIZEDATA], reg_b[SIZEDATA], reg_op[SIZEOP].
- Rising CLK with RESET=1: all three registers cleared to 0; RESET has priority over buttons.
- Otherwise, each register loads independently when its button is high (level-sensitive, no edge detect):
  - BUTTONS[0]: reg_a <= SWITCHES
  - BUTTONS[1]: reg_b <= SWITCHES
  - BUTTONS[2]: reg_op <= SWITCHES[SIZEOP-1:0]
- Several buttons high together load the same switch value into every selected register in the same cycle.
- Holding a button reloads every cycle; with no button high, registers hold their values.
- LEDS = ALU(reg_a, reg_b, reg_op), combinational. Operands are two's complement; result is truncated to SIZEDATA bits with no carry or overflow output.
- Opcodes:
  - 100000 ADD: a+b
  - 100010 SUB: a−b
  - 100100 AND: a&b
  - 100101 OR: a|b
  - 100110 XOR: a^b
  - 100111 NOR: ~(a|b)
  - 000010 SRL: a shifted right logically by unsigned reg_b; zero fill
  - 000011 SRA: a shifted right arithmetically by unsigned reg_b; sign fill
- Shift amount uses the full unsigned value of reg_b. For reg_b ≥ SIZEDATA: SRL gives 0; SRA gives all copies of a[MSB].
- Any other opcode, including the reset value 0: LEDS = 0.

## Timing
- Latency: a button sampled high at edge N updates its register at edge N. LEDS reflect the new value combinationally after that edge, i.e. valid before edge N+1.
- After reset: LEDS = 0, since opcode 0 is not a valid operation.
- Reset asserted mid-sequence: at the next edge all registers clear and LEDS = 0 regardless of BUTTONS.
- SWITCHES changing while no button is high has no effect on LEDS.

## Structure
- Shared package alu_pkg holds SIZEDATA/SIZEOP defaults and the eight opcode constants (ADD, SUB, AND, OR, XOR, NOR, SRL, SRA).
- One sub-module, alu: purely combinational, inputs a, b, op, output result, parameterised by SIZEDATA/SIZEOP.
- alu_top contains only the three capture registers and the alu instance.

## Test plan
- Reset: RESET=1 for one edge with BUTTONS=111 and SWITCHES=0xFF -> registers 0, LEDS=0x00.
- ADD/SUB: A=0x05, B=0x03, op=ADD -> LEDS=0x08. Then op=SUB with A=0x03, B=0x05 -> 0xFE. Overflow case A=0x7F, B=0x01, ADD -> 0x80.
- Logic: A=0x0F, B=0x3C -> AND 0x0C, OR 0x3F, XOR 0x33, NOR 0xC0.
- Shifts: A=0x90, B=3 -> SRL 0x12, SRA 0xF2. B=9 -> SRL 0x00, SRA 0xFF.
- Load control: load A=0x05; change SWITCHES to 0xAA with no button high -> reg_a unchanged, LEDS unchanged. BUTTONS=011 with SWITCHES=0x04, op=ADD -> LEDS=0x08.
- Invalid opcode: op=000000 or 111111 with any A/B -> LEDS=0x00. Assert RESET mid-operation after a valid ADD -> LEDS=0x00 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the board-level ALU: default widths and opcode encodings.
package alu_pkg;

  localparam int DEF_SIZEDATA = 8;
  localparam int DEF_SIZEOP   = 6;
  localparam int DEF_NBUTTONS = 3;

  // Opcode encodings; anything not listed here drives a zero result.
  typedef enum logic [5:0] {
    OP_SRL = 6'b000010,
    OP_SRA = 6'b000011,
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_NOR = 6'b100111
  } aluOp_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU: eight operations on two's complement operands,
// result truncated to the operand width with no carry or overflow flag.
module alu
  import alu_pkg::*;
#(
  parameter int SIZEDATA = DEF_SIZEDATA,
  parameter int SIZEOP   = DEF_SIZEOP
) (
  input  logic [SIZEDATA-1:0] a,
  input  logic [SIZEDATA-1:0] b,
  input  logic [SIZEOP-1:0]   op,
  output logic [SIZEDATA-1:0] result
);

  // Select the operation; shifts use the full unsigned b, so large amounts
  // naturally flush to zero (logical) or to copies of the sign bit (arithmetic).
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SRL:  result = a >> b;
      OP_SRA:  result = $unsigned($signed(a) >>> b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_top.sv
// Board-level ALU wrapper: operand A, operand B and opcode are captured from a
// shared switch bank under button control and the ALU result drives the LEDs.
module alu_top
  import alu_pkg::*;
#(
  parameter int SIZEDATA  = DEF_SIZEDATA,
  parameter int SIZEOP    = DEF_SIZEOP,
  parameter int N_BUTTONS = DEF_NBUTTONS
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [SIZEDATA-1:0]  SWITCHES,
  input  logic [N_BUTTONS-1:0] BUTTONS,
  output logic [SIZEDATA-1:0]  LEDS
);

  logic [SIZEDATA-1:0] r_regA;
  logic [SIZEDATA-1:0] r_regB;
  logic [SIZEOP-1:0]   r_regOp;
  logic [SIZEDATA-1:0] w_aluResult;

  // Capture registers: reset wins, otherwise each button independently
  // reloads its register every cycle it is held high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_regA  <= '0;
      r_regB  <= '0;
      r_regOp <= '0;
    end else begin
      if (BUTTONS[0]) r_regA  <= SWITCHES;
      if (BUTTONS[1]) r_regB  <= SWITCHES;
      if (BUTTONS[2]) r_regOp <= SWITCHES[SIZEOP-1:0];
    end
  end

  alu #(
    .SIZEDATA(SIZEDATA),
    .SIZEOP  (SIZEOP)
  ) u_alu (
    .a     (r_regA),
    .b     (r_regB),
    .op    (r_regOp),
    .result(w_aluResult)
  );

  assign LEDS = w_aluResult;

endmodule

// File: tb/tb_alu_top.sv
// Directed self-checking bench for alu_top with hand-computed LED values.
module tb_alu_top;

  logic       CLK;
  logic       RESET;
  logic [7:0] SWITCHES;
  logic [2:0] BUTTONS;
  logic [7:0] LEDS;

  int total;
  int bad;

  alu_top #(
    .SIZEDATA (8),
    .SIZEOP   (6),
    .N_BUTTONS(3)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .SWITCHES(SWITCHES),
    .BUTTONS (BUTTONS),
    .LEDS    (LEDS)
  );

  // Free-running 100 MHz clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Drive inputs on the falling edge, let one rising edge sample them,
  // then settle just after the edge so LEDS can be observed.
  task automatic applyStimulus(input logic rst, input logic [2:0] btn, input logic [7:0] sw);
    @(negedge CLK);
    RESET    = rst;
    BUTTONS  = btn;
    SWITCHES = sw;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic loadA(input logic [7:0] v);
    applyStimulus(1'b0, 3'b001, v);
  endtask

  task automatic loadB(input logic [7:0] v);
    applyStimulus(1'b0, 3'b010, v);
  endtask

  task automatic loadOp(input logic [5:0] v);
    applyStimulus(1'b0, 3'b100, {2'b00, v});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    RESET    = 1'b0;
    BUTTONS  = 3'b000;
    SWITCHES = 8'h00;

    // Reset has priority over all buttons held high.
    applyStimulus(1'b1, 3'b111, 8'hFF);
    checkOutput("reset", LEDS, 8'h00);
    loadOp(6'b100000);
    checkOutput("reset_regs_cleared_add", LEDS, 8'h00);

    // Arithmetic
    loadA(8'h05);
    loadB(8'h03);
    checkOutput("add_5_3", LEDS, 8'h08);
    loadA(8'h03);
    loadB(8'h05);
    loadOp(6'b100010);
    checkOutput("sub_3_5", LEDS, 8'hFE);
    loadA(8'h7F);
    loadB(8'h01);
    loadOp(6'b100000);
    checkOutput("add_overflow", LEDS, 8'h80);

    // Logic
    loadA(8'h0F);
    loadB(8'h3C);
    loadOp(6'b100100);
    checkOutput("and", LEDS, 8'h0C);
    loadOp(6'b100101);
    checkOutput("or", LEDS, 8'h3F);
    loadOp(6'b100110);
    checkOutput("xor", LEDS, 8'h33);
    loadOp(6'b100111);
    checkOutput("nor", LEDS, 8'hC0);

    // Shifts, including amounts at and beyond the operand width
    loadA(8'h90);
    loadB(8'h03);
    loadOp(6'b000010);
    checkOutput("srl_3", LEDS, 8'h12);
    loadOp(6'b000011);
    checkOutput("sra_3", LEDS, 8'hF2);
    loadB(8'h09);
    checkOutput("sra_9", LEDS, 8'hFF);
    loadOp(6'b000010);
    checkOutput("srl_9", LEDS, 8'h00);
    loadB(8'h08);
    checkOutput("srl_8", LEDS, 8'h00);
    loadB(8'h00);
    checkOutput("srl_0", LEDS, 8'h90);
    loadA(8'h70);
    loadB(8'hFF);
    loadOp(6'b000011);
    checkOutput("sra_pos_255", LEDS, 8'h00);

    // Load control: switches ignored without a button
    loadA(8'h05);
    loadB(8'h03);
    loadOp(6'b100000);
    checkOutput("load_add", LEDS, 8'h08);
    applyStimulus(1'b0, 3'b000, 8'hAA);
    applyStimulus(1'b0, 3'b000, 8'h55);
    checkOutput("hold_no_button", LEDS, 8'h08);
    applyStimulus(1'b0, 3'b011, 8'h04);
    checkOutput("load_a_b_together", LEDS, 8'h08);
    applyStimulus(1'b0, 3'b111, 8'h20);
    checkOutput("load_all_together", LEDS, 8'h40);

    // Invalid opcodes
    loadA(8'h12);
    loadB(8'h34);
    loadOp(6'b000000);
    checkOutput("op_000000", LEDS, 8'h00);
    loadOp(6'b111111);
    checkOutput("op_111111", LEDS, 8'h00);

    // Reset in the middle of a valid operation
    loadOp(6'b100000);
    checkOutput("pre_reset_add", LEDS, 8'h46);
    applyStimulus(1'b1, 3'b111, 8'h20);
    checkOutput("mid_reset", LEDS, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
